hack_cpu_core: RTL and testbench
================================

# hack_cpu_core

Multi-cycle Hack CPU sequencer that sits directly upstream of the ALU: it fetches instructions and drives the ALU's X/Y operands and six control bits. It also consumes the ALU's OUT/ZR/NG results to update the A, D and PC registers and to write data memory. Instruction ROM and data RAM sit behind simple req/ack ports, so block RAM, SPI flash or memory-mapped I/O with variable latency can be attached.

## Interface
Parameters
- none; data width fixed at 16, address width fixed at 15.

Ports
- CLK  in  1  sole clock; all state changes on rising edge.
- RESET_N  in  1  reset, synchronous, active-low.
- IREQ  out  1  instruction fetch request.
- IADDR  out  15  fetch address (= PC).
- IACK  in  1  fetch complete; IDATA valid this cycle.
- IDATA  in  16  instruction word.
- DREQ  out  1  data access request.
- DWE  out  1  1 = write, 0 = read; valid while DREQ.
- DADDR  out  15  data address.
- DWDATA  out  16  write data.
- DACK  in  1  access complete; DRDATA valid on read.
- DRDATA  in  16  read data.
- RETIRE  out  1  one-cycle pulse per completed instruction.
- A_REG, D_REG  out  16 each  architectural registers, for debug.
- PC  out  15  program counter.

## Operation
- Instantiates the team's ALU.
  - X = D.
  - Y = IR[12] ? MREG : A.
  - ZX..NO = IR[11:6].
- Instruction decode:
  - IR[15]=0: A-instruction.
  - IR[15]=1: C-instruction, with a=IR[12], dest A/D/M = IR[5]/IR[4]/IR[3], jump lt/eq/gt = IR[2]/IR[1]/IR[0].
  - IR[14:13] ignored.
- States:
  - FETCH: IREQ=1, IADDR=PC. On IACK, IR<=IDATA, go to DECODE.
  - DECODE, A-instruction: A<=IR, PC<=PC+1, RETIRE, go to FETCH.
  - DECODE, C-instruction: a=1 goes to LOAD, else EXEC.
  - LOAD: DREQ=1, DWE=0, DADDR=A[14:0]. On DACK, MREG<=DRDATA, go to EXEC.
  - EXEC, data capture: latch SADDR<=A[14:0] (old A) and SDATA<=ALU OUT.
  - EXEC, register writes: if dest A, A<=OUT; if dest D, D<=OUT.
  - EXEC, jump test: jump = (lt & NG) | (eq & ZR) | (gt & ~NG & ~ZR).
  - EXEC, PC update: PC <= jump ? old A[14:0] : PC+1.
  - EXEC, next state: dest M goes to STORE; otherwise RETIRE and go to FETCH.
  - STORE: DREQ=1, DWE=1, DADDR=SADDR, DWDATA=SDATA. On DACK, RETIRE, go to FETCH.
- All register updates in EXEC use pre-instruction values of A and D; simultaneous dest A and jump jumps to the old A.
- PC+1 wraps 0x7FFF to 0x0000 silently.
- REQ stays high until ACK and is deasserted the cycle after ACK. An ACK while REQ is low is ignored.
- DADDR, DWE and DWDATA hold stable while DREQ=1; IADDR holds stable while IREQ=1.

## Timing
- Reset (RESET_N low at an edge) loads these values:
  - state=FETCH; PC=0, A=0, D=0, IR=0, MREG=0; RETIRE=0.
  - IREQ and DREQ are forced to 0 while RESET_N is low.
- First IREQ (IADDR=0) occurs in the first cycle after RESET_N rises.
- Reset mid-transaction aborts the access; an ACK arriving during reset is ignored, and no store is committed unless DACK was sampled before the reset edge.
- Cycles per instruction with zero-wait memory (ACK in the same cycle as REQ):
  - A-instruction: 2.
  - C-instruction without M read or write: 3.
  - C-instruction with M read: +1.
  - C-instruction with M write: +1.
- Each wait cycle on IACK or DACK adds one cycle and changes no state.
- RETIRE is asserted in the final cycle of each instruction.

## Configuration
- HACK_CPU_INSTRET_EN defined:
  - Adds output INSTRET (32 bits), an instruction count that increments on every RETIRE.
  - Reset value 0; wraps 0xFFFFFFFF to 0.
- HACK_CPU_INSTRET_EN not defined: neither the port nor the counter exists; all other behaviour is identical.

## Test plan
- Reset, then ROM[0]=0x0005 with zero-wait memory -> IADDR=0 in the first cycle, A_REG=5 and PC=1 after 2 cycles, one RETIRE pulse.
- Program @7; D=A; @3; D=D+A (0xEC10 is D=A, 0xE090 is D=D+A) -> D_REG=10, A_REG=3, PC=4, 10 cycles total.
- Program @100; M=1 (0xEFC8) -> DREQ=1, DWE=1, DADDR=100, DWDATA=1; store holds 3 extra cycles until DACK, then RETIRE.
- RAM[2]=0xFFFF, program @2; D=M; @9; D;JLT (0xE304) -> PC=9 after the jump. A second run with RAM[2]=1 -> PC=4.
- PC=0x7FFF executing an A-instruction -> PC wraps to 0x0000 and the next IADDR=0.
- RESET_N dropped during LOAD with DACK arriving in the same cycle -> no MREG/D update, PC=0, FETCH restarts at address 0. With HACK_CPU_INSTRET_EN, INSTRET=0.

Source files
------------

// File: rtl/hack_cpu_core.sv
// Multi-cycle Hack CPU sequencer: FETCH/DECODE/LOAD/EXEC/STORE over req/ack memory ports.
// Define HACK_CPU_INSTRET_EN to add the 32-bit INSTRET retired-instruction counter port.
module hack_cpu_core (
    input  logic        CLK,
    input  logic        RESET_N,
    output logic        IREQ,
    output logic [14:0] IADDR,
    input  logic        IACK,
    input  logic [15:0] IDATA,
    output logic        DREQ,
    output logic        DWE,
    output logic [14:0] DADDR,
    output logic [15:0] DWDATA,
    input  logic        DACK,
    input  logic [15:0] DRDATA,
    output logic        RETIRE,
    output logic [15:0] A_REG,
    output logic [15:0] D_REG,
    output logic [14:0] PC
`ifdef HACK_CPU_INSTRET_EN
    ,
    output logic [31:0] INSTRET
`endif
);

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_LOAD,
        ST_EXEC,
        ST_STORE
    } state_e;

    typedef struct packed {
        logic [15:0] out;
        logic        zr;
        logic        ng;
    } alu_res_t;

    // The team's Hack ALU: ctrl = {zx, nx, zy, ny, f, no}.
    function automatic alu_res_t hack_alu(input logic [15:0] x_in,
                                          input logic [15:0] y_in,
                                          input logic [5:0]  ctrl);
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] o;
        alu_res_t    res;
        x = ctrl[5] ? 16'h0000 : x_in;
        x = ctrl[4] ? ~x : x;
        y = ctrl[3] ? 16'h0000 : y_in;
        y = ctrl[2] ? ~y : y;
        o = ctrl[1] ? (x + y) : (x & y);
        o = ctrl[0] ? ~o : o;
        res.out = o;
        res.zr  = (o == 16'h0000);
        res.ng  = o[15];
        return res;
    endfunction

    state_e      state_q, state_d;
    logic [14:0] pc_q, pc_d;
    logic [15:0] areg_q, areg_d;
    logic [15:0] dreg_q, dreg_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] mreg_q, mreg_d;
    logic [14:0] saddr_q, saddr_d;
    logic [15:0] sdata_q, sdata_d;

    logic        ireq;
    logic        dreq;
    logic        dwe;
    logic [14:0] daddr;
    logic        retire;

    logic        is_c;
    logic        use_m;
    logic        dest_a;
    logic        dest_d;
    logic        dest_m;
    logic        jump;
    logic [14:0] pc_inc;
    alu_res_t    alu;

    assign is_c   = ir_q[15];
    assign use_m  = ir_q[12];
    assign dest_a = ir_q[5];
    assign dest_d = ir_q[4];
    assign dest_m = ir_q[3];
    assign pc_inc = pc_q + 15'd1;

    assign alu  = hack_alu(dreg_q, use_m ? mreg_q : areg_q, ir_q[11:6]);
    assign jump = (ir_q[2] & alu.ng) | (ir_q[1] & alu.zr) | (ir_q[0] & ~alu.ng & ~alu.zr);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_d = state_q;
        pc_d    = pc_q;
        areg_d  = areg_q;
        dreg_d  = dreg_q;
        ir_d    = ir_q;
        mreg_d  = mreg_q;
        saddr_d = saddr_q;
        sdata_d = sdata_q;
        ireq    = 1'b0;
        dreq    = 1'b0;
        dwe     = 1'b0;
        daddr   = areg_q[14:0];
        retire  = 1'b0;

        unique case (state_q)
            ST_FETCH: begin
                ireq = 1'b1;
                if (IACK) begin
                    ir_d    = IDATA;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (!is_c) begin
                    areg_d  = ir_q;
                    pc_d    = pc_inc;
                    retire  = 1'b1;
                    state_d = ST_FETCH;
                end else begin
                    state_d = use_m ? ST_LOAD : ST_EXEC;
                end
            end
            ST_LOAD: begin
                dreq = 1'b1;
                if (DACK) begin
                    mreg_d  = DRDATA;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // Everything here reads the pre-instruction A and D, so dest A plus jump targets the old A.
                saddr_d = areg_q[14:0];
                sdata_d = alu.out;
                if (dest_a) areg_d = alu.out;
                if (dest_d) dreg_d = alu.out;
                pc_d = jump ? areg_q[14:0] : pc_inc;
                if (dest_m) begin
                    state_d = ST_STORE;
                end else begin
                    retire  = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_STORE: begin
                dreq  = 1'b1;
                dwe   = 1'b1;
                daddr = saddr_q;
                if (DACK) begin
                    retire  = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!RESET_N) begin
            state_q <= ST_FETCH;
            pc_q    <= '0;
            areg_q  <= '0;
            dreg_q  <= '0;
            ir_q    <= '0;
            mreg_q  <= '0;
            saddr_q <= '0;
            sdata_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            areg_q  <= areg_d;
            dreg_q  <= dreg_d;
            ir_q    <= ir_d;
            mreg_q  <= mreg_d;
            saddr_q <= saddr_d;
            sdata_q <= sdata_d;
        end
    end

    // Requests and the retire pulse are masked while reset is held so memories never see a stray access.
    assign IREQ   = ireq & RESET_N;
    assign DREQ   = dreq & RESET_N;
    assign RETIRE = retire & RESET_N;
    assign IADDR  = pc_q;
    assign DWE    = dwe;
    assign DADDR  = daddr;
    assign DWDATA = sdata_q;
    assign A_REG  = areg_q;
    assign D_REG  = dreg_q;
    assign PC     = pc_q;

`ifdef HACK_CPU_INSTRET_EN
    logic [31:0] instret_q, instret_d;

    always_comb begin
        instret_d = instret_q;
        if (RETIRE) instret_d = instret_q + 32'd1;
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            instret_q <= '0;
        end else begin
            instret_q <= instret_d;
        end
    end

    assign INSTRET = instret_q;
`endif

endmodule

// File: tb/tb_hack_cpu_core.sv
// Self-checking bench for hack_cpu_core: directed programs plus a randomized run against an ISA-level model.
`timescale 1ns/1ps
module tb_hack_cpu_core;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        IACK = 1'b0;
    logic        DACK = 1'b0;
    logic [15:0] IDATA = 16'h0000;
    logic [15:0] DRDATA = 16'h0000;
    logic        IREQ, DREQ, DWE, RETIRE;
    logic [14:0] IADDR, DADDR, PC;
    logic [15:0] DWDATA, A_REG, D_REG;
`ifdef HACK_CPU_INSTRET_EN
    logic [31:0] INSTRET;
`endif

    always #5 CLK = ~CLK;

    hack_cpu_core dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .IREQ(IREQ), .IADDR(IADDR), .IACK(IACK), .IDATA(IDATA),
        .DREQ(DREQ), .DWE(DWE), .DADDR(DADDR), .DWDATA(DWDATA),
        .DACK(DACK), .DRDATA(DRDATA),
        .RETIRE(RETIRE), .A_REG(A_REG), .D_REG(D_REG), .PC(PC)
`ifdef HACK_CPU_INSTRET_EN
        , .INSTRET(INSTRET)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    logic [15:0] rom     [32768];
    logic [15:0] bus_ram [32768];
    logic [15:0] mdl_ram [32768];

    // Memory responder controls
    bit resp_en  = 1'b0;
    bit rand_lat = 1'b0;
    bit stray_en = 1'b0;
    int i_lat = 0;
    int d_lat = 0;
    int wait_cycles = 0;
    bit i_busy = 1'b0;
    bit d_busy = 1'b0;
    int i_left = 0;
    int d_left = 0;

    // Reference model state (ISA level)
    logic [15:0] m_a = 16'h0000;
    logic [15:0] m_d = 16'h0000;
    logic [14:0] m_pc = 15'h0000;
    int  m_base = 0;
    bit  mon_en = 1'b0;
    bit  pending = 1'b0;
    bit  p_st = 1'b0;
    logic [14:0] p_addr = 15'h0000;
    int  cyc = 0;
    int  tot_cyc = 0;
    int  retired = 0;
    int  last_ret_cyc = 0;

    task automatic model_step(output int base, output bit st, output logic [14:0] st_addr);
        logic [15:0] ins, x, y, o;
        logic [14:0] nxt;
        bit jmp;
        ins = rom[m_pc];
        st = 1'b0;
        st_addr = m_a[14:0];
        if (ins[15] == 1'b0) begin
            m_a  = ins;
            m_pc = m_pc + 15'd1;
            base = 2;
        end else begin
            x = m_d;
            y = ins[12] ? mdl_ram[m_a[14:0]] : m_a;
            if (ins[11]) x = 16'h0000;
            if (ins[10]) x = ~x;
            if (ins[9])  y = 16'h0000;
            if (ins[8])  y = ~y;
            o = ins[7] ? x + y : x & y;
            if (ins[6])  o = ~o;
            jmp = (ins[2] && o[15]) || (ins[1] && o == 16'h0000) || (ins[0] && !o[15] && o != 16'h0000);
            nxt = jmp ? m_a[14:0] : m_pc + 15'd1;
            if (ins[3]) begin
                st = 1'b1;
                mdl_ram[m_a[14:0]] = o;
            end
            if (ins[5]) m_a = o;
            if (ins[4]) m_d = o;
            m_pc = nxt;
            base = 3 + int'(ins[12]) + int'(ins[3]);
        end
    endtask

    // Responder: reacts shortly after each rising edge, so an ACK may land in the same cycle as REQ.
    initial begin
        forever begin
            @(posedge CLK);
            #2;
            if (!resp_en) begin
                i_busy = 1'b0;
                d_busy = 1'b0;
            end else begin
                if (IREQ) begin
                    if (!i_busy) begin
                        i_busy = 1'b1;
                        i_left = rand_lat ? int'($urandom_range(0, 3)) : i_lat;
                    end
                    if (i_left == 0) begin
                        IACK = 1'b1;
                        IDATA = rom[IADDR];
                        i_busy = 1'b0;
                    end else begin
                        IACK = 1'b0;
                        IDATA = 16'($urandom);
                        i_left--;
                        wait_cycles++;
                    end
                end else begin
                    i_busy = 1'b0;
                    IACK = stray_en && ($urandom_range(0, 3) == 0);
                    IDATA = 16'($urandom);
                end
                if (DREQ) begin
                    if (!d_busy) begin
                        d_busy = 1'b1;
                        d_left = rand_lat ? int'($urandom_range(0, 3)) : d_lat;
                    end
                    if (d_left == 0) begin
                        DACK = 1'b1;
                        if (DWE) bus_ram[DADDR] = DWDATA;
                        else     DRDATA = bus_ram[DADDR];
                        d_busy = 1'b0;
                    end else begin
                        DACK = 1'b0;
                        DRDATA = 16'($urandom);
                        d_left--;
                        wait_cycles++;
                    end
                end else begin
                    d_busy = 1'b0;
                    DACK = stray_en && ($urandom_range(0, 3) == 0);
                    DRDATA = 16'($urandom);
                end
            end
        end
    end

    // Monitor: architectural state is compared one cycle after each RETIRE pulse.
    initial begin
        forever begin
            @(negedge CLK);
            if (mon_en) begin
                cyc++;
                tot_cyc++;
                if (pending) begin
                    pending = 1'b0;
                    check("A_REG", A_REG, m_a);
                    check("D_REG", D_REG, m_d);
                    check("PC", PC, m_pc);
                    if (p_st) check("ram_write", bus_ram[p_addr], mdl_ram[p_addr]);
                end
                if (RETIRE) begin
                    model_step(m_base, p_st, p_addr);
                    check("cycles_per_instr", cyc, m_base + wait_cycles);
`ifdef HACK_CPU_INSTRET_EN
                    check("INSTRET", INSTRET, retired);
`endif
                    retired++;
                    last_ret_cyc = tot_cyc;
                    cyc = 0;
                    wait_cycles = 0;
                    pending = 1'b1;
                end
            end
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 32768; i++) begin
            rom[i] = 16'h0000;
            bus_ram[i] = 16'h0000;
            mdl_ram[i] = 16'h0000;
        end
    endtask

    task automatic set_ram(input int addr, input logic [15:0] val);
        bus_ram[addr] = val;
        mdl_ram[addr] = val;
    endtask

    task automatic hold_reset();
        mon_en = 1'b0;
        resp_en = 1'b0;
        IACK = 1'b0;
        DACK = 1'b0;
        RESET_N = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
    endtask

    task automatic release_reset();
        RESET_N = 1'b1;
        m_a = 16'h0000;
        m_d = 16'h0000;
        m_pc = 15'h0000;
        cyc = 0;
        tot_cyc = 0;
        wait_cycles = 0;
        retired = 0;
        pending = 1'b0;
        last_ret_cyc = 0;
        resp_en = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic run_retires(input int n, input int budget);
        bit done;
        done = 1'b0;
        for (int k = 0; k < budget && !done; k++) begin
            @(negedge CLK);
            #1;
            if (retired >= n && !pending) done = 1'b1;
        end
        if (!done) check("retire_timeout", retired, n);
    endtask

    function automatic logic [15:0] rand_instr();
        if ($urandom_range(0, 9) < 4) return {1'b0, 15'($urandom)};
        return {1'b1, 15'($urandom)};
    endfunction

    initial begin
        // Reset state and a single A-instruction
        clear_mem();
        rom[0] = 16'h0005;
        hold_reset();
        check("rst_IREQ", IREQ, 0);
        check("rst_DREQ", DREQ, 0);
        check("rst_RETIRE", RETIRE, 0);
        check("rst_A", A_REG, 0);
        check("rst_D", D_REG, 0);
        check("rst_PC", PC, 0);
        release_reset();
        @(negedge CLK);
        #1;
        check("first_IREQ", IREQ, 1);
        check("first_IADDR", IADDR, 0);
        run_retires(1, 20);
        check("t1_A", A_REG, 16'h0005);
        check("t1_PC", PC, 1);
        check("t1_cycles", last_ret_cyc, 2);
        check("t1_retires", retired, 1);

        // @7; D=A; @3; D=D+A
        clear_mem();
        rom[0] = 16'h0007; rom[1] = 16'hEC10; rom[2] = 16'h0003; rom[3] = 16'hE090;
        hold_reset();
        release_reset();
        run_retires(4, 50);
        check("t2_D", D_REG, 16'd10);
        check("t2_A", A_REG, 16'd3);
        check("t2_PC", PC, 4);
        check("t2_cycles", last_ret_cyc, 10);

        // @100; M=1 with a store held for three wait cycles
        clear_mem();
        rom[0] = 16'h0064; rom[1] = 16'hEFC8;
        d_lat = 3;
        hold_reset();
        release_reset();
        for (int k = 0; k < 20 && !DREQ; k++) begin
            @(negedge CLK);
            #1;
        end
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                @(negedge CLK);
                #1;
            end
            check("st_DREQ", DREQ, 1);
            check("st_DWE", DWE, 1);
            check("st_DADDR", DADDR, 100);
            check("st_DWDATA", DWDATA, 1);
            check("st_RETIRE", RETIRE, k == 3);
        end
        run_retires(2, 50);
        check("st_ram", bus_ram[100], 16'h0001);
        d_lat = 0;

        // @2; D=M; @9; D;JLT taken, then not taken
        for (int run = 0; run < 2; run++) begin
            clear_mem();
            rom[0] = 16'h0002; rom[1] = 16'hFC10; rom[2] = 16'h0009; rom[3] = 16'hE304;
            set_ram(2, run == 0 ? 16'hFFFF : 16'h0001);
            hold_reset();
            release_reset();
            run_retires(4, 60);
            check("jlt_PC", PC, run == 0 ? 9 : 4);
            check("jlt_D", D_REG, run == 0 ? 32'hFFFF : 32'h0001);
        end

        // PC wrap: @0x7FFF; 0;JMP; then the A-instruction at 0x7FFF
        clear_mem();
        rom[0] = 16'h7FFF; rom[1] = 16'hEA87; rom[32767] = 16'h0005;
        hold_reset();
        release_reset();
        run_retires(2, 40);
        check("wrap_PC_top", PC, 15'h7FFF);
        run_retires(3, 40);
        check("wrap_PC", PC, 0);
        check("wrap_A", A_REG, 5);
        check("wrap_IREQ", IREQ, 1);
        check("wrap_IADDR", IADDR, 0);

        // Reset during LOAD with DACK in the same cycle
        clear_mem();
        rom[0] = 16'h0002; rom[1] = 16'hFC10;
        set_ram(2, 16'h1234);
        d_lat = 50;
        hold_reset();
        release_reset();
        for (int k = 0; k < 20 && !DREQ; k++) begin
            @(negedge CLK);
            #1;
        end
        check("abort_in_load", DREQ, 1);
        mon_en = 1'b0;
        resp_en = 1'b0;
        DACK = 1'b1;
        DRDATA = 16'hBEEF;
        RESET_N = 1'b0;
        @(posedge CLK);
        #1;
        DACK = 1'b0;
        check("abort_PC", PC, 0);
        check("abort_A", A_REG, 0);
        check("abort_D", D_REG, 0);
        check("abort_IREQ", IREQ, 0);
        check("abort_DREQ", DREQ, 0);
`ifdef HACK_CPU_INSTRET_EN
        check("abort_INSTRET", INSTRET, 0);
`endif
        d_lat = 0;
        release_reset();
        @(negedge CLK);
        #1;
        check("abort_refetch_IREQ", IREQ, 1);
        check("abort_refetch_IADDR", IADDR, 0);
        run_retires(2, 40);
        check("abort_reload_D", D_REG, 16'h1234);

        // Randomized program, random wait states and stray ACKs
        for (int i = 0; i < 32768; i++) begin
            rom[i] = rand_instr();
            bus_ram[i] = 16'($urandom);
            mdl_ram[i] = bus_ram[i];
        end
        rand_lat = 1'b1;
        stray_en = 1'b1;
        hold_reset();
        release_reset();
        run_retires(600, 15000);
        rand_lat = 1'b0;
        stray_en = 1'b0;
        mon_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
